rv_fetch: RTL

Instruction fetch stage. It owns the PC, issues single-outstanding word reads on the instruction bus, and buffers returned words in a 2-entry FIFO. It presents the head instruction to decode and drives the "instruction available" level that the pipeline controller consumes as its fetch bus acknowledge. It obeys the controller's fetch stall and applies execute-stage redirects (taken branch/jump).

---
 rtl/rv_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rv_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads and
// buffers returned instructions in a 2-entry FIFO whose head is presented to decode.
module rv_fetch #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_stall,
    input  logic            i_pc_sel,
    input  logic [XLEN-1:0] i_pc_target,
    output logic            o_bus_req,
    output logic [XLEN-1:0] o_bus_addr,
    input  logic            i_bus_ack,
    input  logic [XLEN-1:0] i_bus_rdata,
    output logic            o_fetch_ack,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_p4
);

    localparam int unsigned     CNT_W      = 2;
    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] RESET_PC   = RESET_VECTOR & ALIGN_MASK;

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]       state_q,     state_d;
    logic [XLEN-1:0]  pc_q,        pc_d;
    logic             req_q,       req_d;
    logic [XLEN-1:0]  addr_q,      addr_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [XLEN-1:0]  e0_instr_q,  e0_instr_d;
    logic [XLEN-1:0]  e0_pc_q,     e0_pc_d;
    logic [XLEN-1:0]  e1_instr_q,  e1_instr_d;
    logic [XLEN-1:0]  e1_pc_q,     e1_pc_d;
    logic             fetch_ack_q, fetch_ack_d;
    logic [XLEN-1:0]  pc_p4_q,     pc_p4_d;

    logic             pop_c;
    logic             push_c;
    logic [CNT_W-1:0] cnt_pop_c;

    // Next-state logic; entry 0 is always the FIFO head and holds its value when empty
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_d       = req_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        e0_instr_d  = e0_instr_q;
        e0_pc_d     = e0_pc_q;
        e1_instr_d  = e1_instr_q;
        e1_pc_d     = e1_pc_q;

        pop_c     = fetch_ack_q & ~i_stall & ~i_pc_sel;
        push_c    = req_q & i_bus_ack & (state_q == S_RUN) & ~i_pc_sel;
        cnt_pop_c = cnt_q - CNT_W'(pop_c);

        if (i_pc_sel) begin
            cnt_d = '0;
            pc_d  = i_pc_target & ALIGN_MASK;
            if (req_q && !i_bus_ack) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_RUN;
                req_d   = 1'b0;
            end
        end else begin
            if (pop_c && cnt_q == CNT_W'(2)) begin
                e0_instr_d = e1_instr_q;
                e0_pc_d    = e1_pc_q;
            end
            if (push_c) begin
                if (cnt_pop_c == '0) begin
                    e0_instr_d = i_bus_rdata;
                    e0_pc_d    = pc_q;
                end else begin
                    e1_instr_d = i_bus_rdata;
                    e1_pc_d    = pc_q;
                end
                pc_d = pc_q + WORD_BYTES;
            end
            cnt_d = cnt_pop_c + CNT_W'(push_c);

            // Ack closes the request (discarding data in DRAIN); no reissue in the same cycle
            if (req_q && i_bus_ack) begin
                req_d   = 1'b0;
                state_d = S_RUN;
            end else if (!req_q && state_q == S_RUN && cnt_pop_c != CNT_W'(2)) begin
                req_d  = 1'b1;
                addr_d = pc_q;
            end
        end

        fetch_ack_d = (cnt_d != '0);
        pc_p4_d     = (cnt_d != '0) ? (e0_pc_d + WORD_BYTES) : pc_p4_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            e0_instr_q  <= '0;
            e0_pc_q     <= '0;
            e1_instr_q  <= '0;
            e1_pc_q     <= '0;
            fetch_ack_q <= 1'b0;
            pc_p4_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            e0_instr_q  <= e0_instr_d;
            e0_pc_q     <= e0_pc_d;
            e1_instr_q  <= e1_instr_d;
            e1_pc_q     <= e1_pc_d;
            fetch_ack_q <= fetch_ack_d;
            pc_p4_q     <= pc_p4_d;
        end
    end

    assign o_bus_req   = req_q;
    assign o_bus_addr  = addr_q;
    assign o_fetch_ack = fetch_ack_q;
    assign o_instr     = e0_instr_q;
    assign o_pc        = e0_pc_q;
    assign o_pc_p4     = pc_p4_q;

endmodule
